// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the CPU serial debug transmitter.
package debug_uart_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         NUM_PORTS_DEF = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Cycles from accept to done for a frame of sync + payload + extra bytes.
  function automatic int frame_cycles(int num_ports, int clks_per_bit, int extra);
    return (num_ports + 1 + extra) * 10 * clks_per_bit;
  endfunction

endpackage

// File: rtl/debug_uart_tx_if.sv
// Request/line bundle between the CPU top level and the debug transmitter.
interface debug_uart_tx_if
  import debug_uart_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF
);
  logic                      start;
  logic [NUM_PORTS-1:0][7:0] debug_port;  // debug_port[0] is payload byte 1
  logic                      tx;
  logic                      busy;
  logic                      done;

  modport master (output start, debug_port, input tx, busy, done);
  modport slave  (input start, debug_port, output tx, busy, done);
endinterface

// File: rtl/debug_uart_tx_byte.sv
// One 8N1 byte, LSB first. ready_o is also high in the last stop-bit cycle so a
// new byte can be loaded back-to-back with no idle gap.
module uart_byte_tx
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          tick;

  assign tick    = (cnt_q == CNT_LAST);
  assign ready_o = (state_q == IDLE) || ((state_q == STOP) && tick);
  assign tx_o    = tx_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            state_q <= START;
            shift_q <= data_i;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (load_i) begin
              state_q <= START;
              shift_q <= data_i;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug frame transmitter: snapshots the payload ports on start and sends
// sync + payload as contiguous 8N1 bytes. DEBUG_UART_TX_CHECKSUM_EN appends an XOR byte.
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_PORTS    = NUM_PORTS_DEF
) (
  input  logic            clk,
  input  logic            nreset,
  debug_uart_tx_if.slave  bus
);
`ifdef DEBUG_UART_TX_CHECKSUM_EN
  localparam int NBYTES = NUM_PORTS + 2;
`else
  localparam int NBYTES = NUM_PORTS + 1;
`endif
  localparam int             IW       = $clog2(NBYTES);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NBYTES - 1);

  logic [NBYTES-1:0][7:0] frame_d, frame_q;
  logic [IW-1:0]          idx_d, idx_q, nxt_idx;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic                   byte_ready, accept, advance, finish, load;
  logic [7:0]             load_data;
`ifdef DEBUG_UART_TX_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  always_comb begin
    frame_d    = '0;
    frame_d[0] = SYNC_BYTE;
    for (int i = 0; i < NUM_PORTS; i++) frame_d[i+1] = bus.debug_port[i];
`ifdef DEBUG_UART_TX_CHECKSUM_EN
    csum = '0;
    for (int i = 0; i < NUM_PORTS; i++) csum = csum ^ bus.debug_port[i];
    frame_d[NBYTES-1] = csum;
`endif
  end

  // Byte index 0 (sync) goes straight to the serialiser on accept; the rest
  // are fed from the snapshot each time the serialiser reaches its last stop cycle.
  assign nxt_idx   = idx_q + 1'b1;
  assign accept    = !busy_q && bus.start && byte_ready;
  assign advance   = busy_q && byte_ready && (idx_q != IDX_LAST);
  assign finish    = busy_q && byte_ready && (idx_q == IDX_LAST);
  assign load      = accept || advance;
  assign load_data = accept ? SYNC_BYTE : frame_q[nxt_idx];

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    done_d = finish;
    if (accept) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end else if (advance) begin
      idx_d  = nxt_idx;
    end else if (finish) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
      if (accept) frame_q <= frame_d;
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk     (clk),
    .nreset  (nreset),
    .load_i  (load),
    .data_i  (load_data),
    .ready_o (byte_ready),
    .tx_o    (bus.tx)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: two instances (4 and 2 clocks per bit) share stimulus
// and are each checked every cycle against a bit-queue model of the frame.
module tb_debug_uart_tx;
`ifdef DEBUG_UART_TX_CHECKSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  logic            clk = 1'b0;
  logic            nreset;
  logic            start_r;
  logic [6:0][7:0] ports_r;
  int              nerr = 0;
  int              nchk = 0;

  always #5 clk = ~clk;

  debug_uart_tx_if #(.NUM_PORTS(7)) ifc4 ();
  debug_uart_tx_if #(.NUM_PORTS(7)) ifc2 ();
  assign ifc4.start      = start_r;
  assign ifc4.debug_port = ports_r;
  assign ifc2.start      = start_r;
  assign ifc2.debug_port = ports_r;

  debug_uart_tx #(.CLKS_PER_BIT(4), .NUM_PORTS(7)) dut4 (.clk(clk), .nreset(nreset), .bus(ifc4));
  debug_uart_tx #(.CLKS_PER_BIT(2), .NUM_PORTS(7)) dut2 (.clk(clk), .nreset(nreset), .bus(ifc2));

  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  for (genvar G = 0; G < 2; G++) begin : mdl
    localparam int C      = (G == 0) ? 4 : 2;
    localparam int EXPLEN = (G == 0) ? ((XB != 0) ? 360 : 320) : ((XB != 0) ? 180 : 160);
    logic       tx_w, busy_w, done_w;
    bit         q[$];
    bit         done_e;
    bit         was;
    bit         bprev = 1'b0;
    int         dcnt = 0;
    int         k = 0;
    int         blen = 0;
    logic [7:0] rx[$];
    logic [7:0] fb[$];
    logic [7:0] x;
    logic [7:0] sh = '0;

    assign tx_w   = (G == 0) ? ifc4.tx   : ifc2.tx;
    assign busy_w = (G == 0) ? ifc4.busy : ifc2.busy;
    assign done_w = (G == 0) ? ifc4.done : ifc2.done;

    // Model: the frame is a queue of line levels, one per cycle after accept.
    initial begin
      done_e = 1'b0;
      forever begin
        @(posedge clk or negedge nreset);
        if (!nreset) begin
          q.delete();
          done_e = 1'b0;
        end else begin
          was = (q.size() > 0);
          if (was) void'(q.pop_front());
          done_e = was && (q.size() == 0);
          if (!was && start_r) begin
            fb.delete();
            fb.push_back(8'hA5);
            x = 8'h00;
            for (int i = 0; i < 7; i++) begin
              fb.push_back(ports_r[i]);
              x = x ^ ports_r[i];
            end
            if (XB != 0) fb.push_back(x);
            foreach (fb[b]) begin
              for (int c = 0; c < C; c++) q.push_back(1'b0);
              for (int j = 0; j < 8; j++)
                for (int c = 0; c < C; c++) q.push_back(fb[b][j]);
              for (int c = 0; c < C; c++) q.push_back(1'b1);
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        chk($sformatf("dut%0d tx/busy/done", C),
            int'({tx_w, busy_w, done_w}),
            int'({(q.size() > 0) ? q[0] : 1'b1, q.size() > 0, done_e}));
        if (busy_w) begin
          k    = bprev ? k + 1 : 0;
          blen = bprev ? blen + 1 : 1;
          if ((k % C) == (C / 2) && ((k % (10 * C)) / C) >= 1) begin
            if (((k % (10 * C)) / C) <= 8) sh[((k % (10 * C)) / C) - 1] = tx_w;
            if (((k % (10 * C)) / C) == 8) rx.push_back(sh);
          end
        end
        if (done_w) begin
          dcnt++;
          chk($sformatf("dut%0d busy length", C), blen, EXPLEN);
        end
        bprev = busy_w;
      end
    end
  end

  function automatic int get_dcnt(input int g);
    return (g == 0) ? mdl[0].dcnt : mdl[1].dcnt;
  endfunction

  function automatic int get_rxn(input int g);
    return (g == 0) ? mdl[0].rx.size() : mdl[1].rx.size();
  endfunction

  task automatic wait_done(input int g, input int target, input int maxc);
    int n = 0;
    while (get_dcnt(g) < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      nchk++;
      nerr++;
      $display("FAIL timeout dut%0d done count actual=%0d required=%0d", g, get_dcnt(g), target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifc4.busy || ifc2.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      nchk++;
      nerr++;
      $display("FAIL timeout idle busy4=%0d busy2=%0d required=0", ifc4.busy, ifc2.busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic chk_rx(input int g, input int base, input logic [7:0] e [0:8]);
    int nb = 8 + XB;
    int sz = get_rxn(g);
    chk($sformatf("dut%0d rx byte count", g), sz - base, nb);
    for (int i = 0; i < nb; i++)
      if (base + i < sz)
        chk($sformatf("dut%0d rx byte %0d", g, i),
            int'((g == 0) ? mdl[0].rx[base+i] : mdl[1].rx[base+i]), int'(e[i]));
  endtask

  logic [7:0] e1 [0:8] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
  logic [7:0] e5 [0:8] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F};
  logic [7:0] e6 [0:8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] er [0:8];

  initial begin
    int b0, b1, d0, d1;
    nreset  = 1'b0;
    start_r = 1'b0;
    ports_r = '0;
    repeat (3) @(negedge clk);
    chk("reset tx4",   int'(ifc4.tx),   1);
    chk("reset busy4", int'(ifc4.busy), 0);
    chk("reset done4", int'(ifc4.done), 0);
    chk("reset tx2",   int'(ifc2.tx),   1);
    chk("reset busy2", int'(ifc2.busy), 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic frame
    for (int i = 0; i < 7; i++) ports_r[i] = 8'(i + 1);
    b0 = get_rxn(0); d0 = get_dcnt(0);
    pulse_start();
    wait_done(0, d0 + 1, 500);
    chk_rx(0, b0, e1);
    wait_idle();

    // 2: ports and start toggled during the frame
    for (int i = 0; i < 7; i++) ports_r[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) er[i+1] = ports_r[i];
    er[0] = 8'hA5;
    er[8] = er[1] ^ er[2] ^ er[3] ^ er[4] ^ er[5] ^ er[6] ^ er[7];
    b0 = get_rxn(0); d0 = get_dcnt(0);
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      ports_r = '1;
      start_r = 1'($urandom);
      @(negedge clk);
    end
    start_r = 1'b0;
    wait_done(0, d0 + 1, 100);
    repeat (20) @(negedge clk);
    chk("dut4 single frame", get_dcnt(0) - d0, 1);
    chk("dut4 idle after frame", int'(ifc4.busy), 0);
    chk_rx(0, b0, er);
    wait_idle();

    // 3: start held for two frames
    d0 = get_dcnt(0);
    @(negedge clk);
    start_r = 1'b1;
    wait_done(0, d0 + 1, 500);
    repeat (2) @(negedge clk);
    start_r = 1'b0;
    wait_done(0, d0 + 2, 500);
    repeat (5) @(negedge clk);
    chk("dut4 back-to-back dones", get_dcnt(0) - d0, 2);
    wait_idle();

    // 4: reset during byte 3 bit 4
    for (int i = 0; i < 7; i++) ports_r[i] = 8'($urandom);
    d0 = get_dcnt(0); d1 = get_dcnt(1);
    pulse_start();
    repeat (141) @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    chk("async reset tx4",   int'(ifc4.tx),   1);
    chk("async reset busy4", int'(ifc4.busy), 0);
    chk("async reset tx2",   int'(ifc2.tx),   1);
    chk("async reset busy2", int'(ifc2.busy), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    chk("dut4 no done on abort", get_dcnt(0) - d0, 0);
    chk("dut2 no done on abort", get_dcnt(1) - d1, 0);
    for (int i = 0; i < 7; i++) ports_r[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) er[i+1] = ports_r[i];
    er[8] = er[1] ^ er[2] ^ er[3] ^ er[4] ^ er[5] ^ er[6] ^ er[7];
    b0 = get_rxn(0); b1 = get_rxn(1); d0 = get_dcnt(0);
    pulse_start();
    wait_done(0, d0 + 1, 500);
    chk_rx(0, b0, er);
    chk_rx(1, b1, er);
    wait_idle();

    // 5: checksum pattern
    for (int i = 0; i < 7; i++) ports_r[i] = 8'(1 << i);
    b0 = get_rxn(0); d0 = get_dcnt(0);
    pulse_start();
    wait_done(0, d0 + 1, 500);
    chk_rx(0, b0, e5);
    wait_idle();

    // 6: all-zero payload at two clocks per bit
    ports_r = '0;
    b1 = get_rxn(1); d1 = get_dcnt(1);
    pulse_start();
    wait_done(1, d1 + 1, 300);
    chk_rx(1, b1, e6);
    wait_idle();

    // Random frames with random gaps and junk on the ports mid-frame
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 7; i++) ports_r[i] = 8'($urandom);
      d0 = get_dcnt(0);
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 3) == 0) ports_r[$urandom_range(0, 6)] = 8'($urandom);
        @(negedge clk);
      end
      wait_done(0, d0 + 1, 500);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
